// File: rtl/rns_compare_const_pipe.sv
// Three-stage RNS comparator: residue capture, mixed-radix digits,
// reconstruction and lt/eq/gt against a runtime-loadable constant.
module rns_compare_const_pipe #(
    parameter int M1         = 9,
    parameter int M2         = 8,
    parameter int M3         = 7,
    parameter bit SIGNED     = 1'b0,
    parameter int CONST_INIT = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [$clog2(M1)-1:0]               a1_in,
    input  logic [$clog2(M2)-1:0]               a2_in,
    input  logic [$clog2(M3)-1:0]               a3_in,
    input  logic                                const_we,
    input  logic [$clog2(M1*M2*M3):0]           const_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                res_lt_out,
    output logic                                res_eq_out,
    output logic                                res_gt_out,
    output logic                                res_err_out
);

    function automatic int modinv(input int a, input int m);
        int r;
        r = 0;
        for (int i = 1; i < m; i++) begin
            if (r == 0 && (a * i) % m == 1) r = i;
        end
        return r;
    endfunction

    localparam int M     = M1 * M2 * M3;
    localparam int W1    = $clog2(M1);
    localparam int W2    = $clog2(M2);
    localparam int W3    = $clog2(M3);
    localparam int DW    = $clog2(M);
    localparam int CW    = DW + 1;
    localparam int INV12 = modinv(M1 % M2, M2);
    localparam int INV13 = modinv(M1 % M3, M3);
    localparam int INV23 = modinv(M2 % M3, M3);
    localparam int HALF  = (M + 1) / 2;

    logic          advance;
    logic [CW-1:0] const_q;
    logic [CW-1:0] const_sel;

    logic          v1;
    logic [W1-1:0] a1_q;
    logic [W2-1:0] a2_q;
    logic [W3-1:0] a3_q;
    logic [CW-1:0] c1_q;
    logic          e1_q;

    logic          v2;
    logic [W1-1:0] d1_q;
    logic [W2-1:0] d2_q;
    logic [W3-1:0] d3_q;
    logic [CW-1:0] c2_q;
    logic          e2_q;

    int            t2;
    int            t3a;
    int            t3b;
    logic [W2-1:0] d2_n;
    logic [W3-1:0] d3_n;

    int            x;
    int            xs;
    int            cs;
    logic          lt_n;
    logic          eq_n;
    logic          gt_n;

    // One global enable: a stalled output freezes every stage.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign const_sel = const_we ? const_in : const_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            const_q <= CW'(CONST_INIT);
        end else if (const_we) begin
            const_q <= const_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1_q <= '0;
            a2_q <= '0;
            a3_q <= '0;
            c1_q <= '0;
            e1_q <= 1'b0;
        end else if (advance) begin
            v1   <= in_valid;
            a1_q <= a1_in;
            a2_q <= a2_in;
            a3_q <= a3_in;
            c1_q <= const_sel;
            e1_q <= (int'(a1_in) >= M1) || (int'(a2_in) >= M2)
                 || (int'(a3_in) >= M3);
        end
    end

    // Mixed-radix digits; +Mi keeps every difference non-negative.
    always_comb begin
        t2   = (int'(a2_q) + M2 - int'(a1_q) % M2) % M2 * INV12 % M2;
        t3a  = (int'(a3_q) + M3 - int'(a1_q) % M3) % M3 * INV13 % M3;
        t3b  = (t3a + M3 - t2 % M3) % M3 * INV23 % M3;
        d2_n = W2'(t2);
        d3_n = W3'(t3b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
            c2_q <= '0;
            e2_q <= 1'b0;
        end else if (advance) begin
            v2   <= v1;
            d1_q <= a1_q;
            d2_q <= d2_n;
            d3_q <= d3_n;
            c2_q <= c1_q;
            e2_q <= e1_q;
        end
    end

    always_comb begin
        x = int'(d1_q) + M1 * int'(d2_q) + M1 * M2 * int'(d3_q);
        if (SIGNED) begin
            xs = (x >= HALF) ? x - M : x;
            cs = int'(signed'(c2_q));
        end else begin
            xs = x;
            cs = int'(c2_q);
        end
        lt_n = xs < cs;
        eq_n = xs == cs;
        gt_n = xs > cs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            res_lt_out  <= 1'b0;
            res_eq_out  <= 1'b0;
            res_gt_out  <= 1'b0;
            res_err_out <= 1'b0;
        end else if (advance) begin
            out_valid <= v2;
            if (v2) begin
                res_lt_out  <= lt_n && !e2_q;
                res_eq_out  <= eq_n && !e2_q;
                res_gt_out  <= gt_n && !e2_q;
                res_err_out <= e2_q;
            end
        end
    end

endmodule

// File: tb/tb_rns_compare_const_pipe.sv
// Bench for rns_compare_const_pipe: unsigned and signed instances,
// results checked against a CRT-search reference model.
module tb_rns_compare_const_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid, in_ready, const_we, out_valid, out_ready;
    logic [3:0] a1_in;
    logic [2:0] a2_in, a3_in;
    logic [9:0] const_in;
    logic       res_lt, res_eq, res_gt, res_err;

    logic       s_in_valid, s_in_ready, s_const_we, s_out_valid, s_out_ready;
    logic [3:0] s_a1;
    logic [2:0] s_a2, s_a3;
    logic [9:0] s_const_in;
    logic       s_lt, s_eq, s_gt, s_err;

    int total = 0;
    int passed = 0;
    int n_pop = 0;
    logic [9:0] mconst = 10'd10;
    logic [9:0] sconst = 10'd10;
    logic [3:0] exp_q[$];
    bit rnd_done;

    always #5 clk = ~clk;

    rns_compare_const_pipe u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in),
        .const_we(const_we), .const_in(const_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_lt_out(res_lt), .res_eq_out(res_eq),
        .res_gt_out(res_gt), .res_err_out(res_err)
    );

    rns_compare_const_pipe #(.SIGNED(1'b1)) u_sdut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a1_in(s_a1), .a2_in(s_a2), .a3_in(s_a3),
        .const_we(s_const_we), .const_in(s_const_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .res_lt_out(s_lt), .res_eq_out(s_eq),
        .res_gt_out(s_gt), .res_err_out(s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {lt, eq, gt, err}; X found by searching for the CRT preimage.
    function automatic logic [3:0] model(input int r1, input int r2,
                                         input int r3, input logic [9:0] c,
                                         input bit sgn);
        int x, xv, cv;
        if (r1 >= 9 || r2 >= 8 || r3 >= 7) return 4'b0001;
        x = 0;
        for (int i = 0; i < 504; i++)
            if (i % 9 == r1 && i % 8 == r2 && i % 7 == r3) x = i;
        xv = (sgn && x >= 252) ? x - 504 : x;
        cv = sgn ? int'($signed(c)) : int'(c);
        return {xv < cv, xv == cv, xv > cv, 1'b0};
    endfunction

    // Output monitor for the unsigned instance.
    bit stalled = 1'b0;
    logic [3:0] held;
    always @(negedge clk) begin
        logic [3:0] e;
        #2;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", {out_valid, res_lt, res_eq, res_gt, res_err},
                      {1'b1, held});
            if (out_valid && !out_ready)
                check("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {res_lt, res_eq, res_gt, res_err}, e);
                    n_pop++;
                end
            end
            stalled = out_valid && !out_ready;
            held = {res_lt, res_eq, res_gt, res_err};
        end
    end

    task automatic push(input int r1, input int r2, input int r3,
                        input bit we, input logic [9:0] cin);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a1_in = 4'(r1);
        a2_in = 3'(r2);
        a3_in = 3'(r3);
        const_we = we;
        const_in = cin;
        if (we) mconst = cin;
        while (!done) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(model(r1, r2, r3, mconst, 1'b0));
                done = 1'b1;
            end else if (n == 50) begin
                check("accept_timeout", in_ready, 1);
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        const_we = 1'b0;
    endtask

    task automatic push_x(input int x, input bit we, input logic [9:0] cin);
        push(x % 9, x % 8, x % 7, we, cin);
    endtask

    task automatic lat_run(input int x, input logic [3:0] exp);
        push_x(x, 1'b0, 10'd0);
        @(negedge clk); #3 check("lat_c1", out_valid, 0);
        @(negedge clk); #3 check("lat_c2", out_valid, 0);
        @(negedge clk); #3 check("lat_c3", out_valid, 1);
        check("directed", {res_lt, res_eq, res_gt, res_err}, exp);
    endtask

    task automatic s_run(input int x, input bit we, input logic [9:0] cin,
                         input bit dir, input logic [3:0] exp_dir);
        int n;
        logic [3:0] e;
        @(negedge clk);
        s_in_valid = 1'b1;
        s_a1 = 4'(x % 9);
        s_a2 = 3'(x % 8);
        s_a3 = 3'(x % 7);
        s_const_we = we;
        s_const_in = cin;
        if (we) sconst = cin;
        e = model(x % 9, x % 8, x % 7, sconst, 1'b1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_const_we = 1'b0;
        n = 0;
        while (!s_out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("s_latency", n, 3);
        check("s_result", {s_lt, s_eq, s_gt, s_err}, e);
        if (dir) check("s_directed", {s_lt, s_eq, s_gt, s_err}, exp_dir);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, x, mode, r1, r3;
        bit we;
        logic [9:0] cin;

        in_valid = 0; const_we = 0; const_in = '0; out_ready = 1;
        a1_in = '0; a2_in = '0; a3_in = '0;
        s_in_valid = 0; s_const_we = 0; s_const_in = '0; s_out_ready = 1;
        s_a1 = '0; s_a2 = '0; s_a3 = '0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_res", {res_lt, res_eq, res_gt, res_err}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_s_out_valid", s_out_valid, 0);
        rst_n = 1'b1;

        lat_run(10, 4'b0100);
        lat_run(11, 4'b0010);
        lat_run(0, 4'b1000);

        n0 = n_pop;
        for (int i = 0; i < 504; i++) push_x(i, 1'b0, 10'd0);
        repeat (3) @(negedge clk);
        #4 check("sweep_count", n_pop - n0, 504);

        n0 = n_pop;
        fork
            begin
                for (int i = 0; i < 5; i++) push_x(100 + 37 * i, 1'b0, 10'd0);
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        #4 check("stall_count", n_pop - n0, 5);
        check("stall_drain", exp_q.size(), 0);

        push_x(499, 1'b0, 10'd0);
        push_x(500, 1'b1, 10'd500);
        push(9, 0, 0, 1'b0, 10'd0);
        push(0, 0, 7, 1'b0, 10'd0);
        push_x(503, 1'b1, 10'd1023);
        push_x(503, 1'b1, 10'd504);
        push_x(503, 1'b1, 10'd503);

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    x = $urandom_range(0, 503);
                    mode = $urandom_range(0, 9);
                    r1 = (mode == 0) ? $urandom_range(9, 15) : x % 9;
                    r3 = (mode == 1) ? 7 : x % 7;
                    we = ($urandom_range(0, 5) == 0);
                    cin = ($urandom_range(0, 1) == 0) ? 10'(x)
                                                      : 10'($urandom_range(0, 1023));
                    push(r1, x % 8, r3, we, cin);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #4 check("random_drain", exp_q.size(), 0);

        push_x(10, 1'b1, 10'd10);
        push_x(20, 1'b0, 10'd0);
        push_x(30, 1'b0, 10'd0);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_mid_valid", out_valid, 0);
        check("rst_mid_res", {res_lt, res_eq, res_gt, res_err}, 0);
        exp_q.delete();
        mconst = 10'd10;
        sconst = 10'd10;
        @(negedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #3 check("no_stale", out_valid, 0);
        end
        push_x(200, 1'b1, 10'd200);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        mconst = 10'd10;
        #3 rst_n = 1'b1;
        lat_run(10, 4'b0100);
        lat_run(9, 4'b1000);

        s_run(503, 1'b0, 10'd0, 1'b1, 4'b1000);
        s_run(252, 1'b0, 10'd0, 1'b1, 4'b1000);
        s_run(251, 1'b0, 10'd0, 1'b1, 4'b0010);
        s_run(503, 1'b1, 10'h3FF, 1'b1, 4'b0100);
        s_run(251, 1'b0, 10'd0, 1'b1, 4'b0010);
        s_run(252, 1'b0, 10'd0, 1'b1, 4'b1000);
        s_run(0, 1'b1, 10'h200, 1'b1, 4'b0010);
        for (int i = 0; i < 20; i++) begin
            x = $urandom_range(0, 503);
            we = ($urandom_range(0, 1) == 0);
            cin = ($urandom_range(0, 1) == 0) ? 10'((x >= 252) ? x - 504 : x)
                                              : 10'($urandom_range(0, 1023));
            s_run(x, we, cin, 1'b0, 4'b0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
